// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller.
//   state_e    : controller FSM states
//   FWD_*      : ALU operand forwarding select codes
//   RESULT_SRC_LOAD : ResultSrcE encoding that marks a load in Execute
//   sat_inc32  : saturating 32-bit increment used by the performance counters
package hazard_pkg;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StMemWait,
    StErr
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
//   master : the pipeline (drives register indices, enables, memory handshake;
//            receives forwarding selects, stall/flush controls, error, counters)
//   slave  : hazard_ctrl
interface hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5
);

  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [REG_ADDR_W-1:0] RdE;
  logic [REG_ADDR_W-1:0] RdM;
  logic [REG_ADDR_W-1:0] RdW;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic [1:0]            ResultSrcE;
  logic                  PCSrcE;
  logic                  MemReqM;
  logic                  mem_ready;

  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  StallM;
  logic                  FlushD;
  logic                  FlushE;
  logic                  FlushW;
  logic                  mem_err;
  logic [31:0]           perf_stall;
  logic [31:0]           perf_flush;
  logic [31:0]           perf_memwait;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, mem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_err, perf_stall, perf_flush, perf_memwait
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, mem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_err, perf_stall, perf_flush, perf_memwait
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational operand forwarding for one Execute-stage source register.
//   rs_e_i          : source register index in Execute
//   rd_m_i, rd_w_i  : destination indices in Memory / Writeback
//   reg_write_m_i/w_i : destination write enables
//   fwd_o           : FWD_MEM, FWD_WB or FWD_RF (Memory stage has priority)
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e_i,
  input  logic [REG_ADDR_W-1:0] rd_m_i,
  input  logic [REG_ADDR_W-1:0] rd_w_i,
  input  logic                  reg_write_m_i,
  input  logic                  reg_write_w_i,
  output logic [1:0]            fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-sequencing controller for the 5-stage RISC-V core.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : hazard_ctrl_if.slave -- register indices, write enables, load
//                marker, branch resolution and data-memory handshake in;
//                forwarding selects, F/D/E/M stalls, D/E/W flushes, sticky
//                mem_err and performance counters out.
// Optional feature: define HAZARD_PERF_EN to build the saturating stall /
// flush / memory-wait counters; otherwise the perf ports read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W    = 5,
  parameter int unsigned STARTUP_FLUSH = 2,
  parameter int unsigned MEM_TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  localparam int unsigned InitW    = $clog2(STARTUP_FLUSH + 1);
  localparam int unsigned TimeoutW = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q;
  logic [InitW-1:0]    init_cnt_q;
  logic [TimeoutW-1:0] to_cnt_q;
  logic                mem_err_q;

  logic [1:0] fwd_a, fwd_b;
  logic       lw_stall, mem_stall;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_ae, fwd_be;

  hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_e_i        (bus.Rs1E),
    .rd_m_i        (bus.RdM),
    .rd_w_i        (bus.RdW),
    .reg_write_m_i (bus.RegWriteM),
    .reg_write_w_i (bus.RegWriteW),
    .fwd_o         (fwd_a)
  );

  hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_e_i        (bus.Rs2E),
    .rd_m_i        (bus.RdM),
    .rd_w_i        (bus.RdW),
    .reg_write_m_i (bus.RegWriteM),
    .reg_write_w_i (bus.RegWriteW),
    .fwd_o         (fwd_b)
  );

  always_comb begin
    lw_stall  = (bus.ResultSrcE == RESULT_SRC_LOAD) && (bus.RdE != '0) &&
                ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    mem_stall = bus.MemReqM && !bus.mem_ready;
  end

  // Control outputs decode the current state plus same-cycle hazards.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    fwd_ae  = FWD_RF;
    fwd_be  = FWD_RF;
    unique case (state_q)
      StInit: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_w = 1'b1;
      end
      StRun: begin
        fwd_ae = fwd_a;
        fwd_be = fwd_b;
        if (mem_stall) begin
          // Freeze the whole front of the pipe; W gets a bubble.
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
        end else if (bus.PCSrcE) begin
          // A taken branch squashes the load-use victim anyway.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else begin
          stall_f = lw_stall;
          stall_d = lw_stall;
          flush_e = lw_stall;
        end
      end
      StMemWait: begin
        fwd_ae  = fwd_a;
        fwd_be  = fwd_b;
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end
      StErr: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      init_cnt_q <= InitW'(STARTUP_FLUSH);
      to_cnt_q   <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q - InitW'(1);
          if (init_cnt_q == InitW'(1)) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (mem_stall) begin
            state_q  <= StMemWait;
            to_cnt_q <= '0;
          end
        end
        StMemWait: begin
          if (bus.mem_ready) begin
            state_q  <= StRun;
            to_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TimeoutW'(1);
            // Counter is about to reach MEM_TIMEOUT-1: give up.
            if (to_cnt_q == TimeoutW'(MEM_TIMEOUT - 2)) begin
              state_q   <= StErr;
              mem_err_q <= 1'b1;
            end
          end
        end
        StErr: begin
          state_q <= StErr;
        end
      endcase
    end
  end

  assign bus.ForwardAE = fwd_ae;
  assign bus.ForwardBE = fwd_be;
  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_d;
  assign bus.StallE    = stall_e;
  assign bus.StallM    = stall_m;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.FlushW    = flush_w;
  assign bus.mem_err   = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_memwait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
      perf_memwait_q <= '0;
    end else begin
      if (stall_f) begin
        perf_stall_q <= sat_inc32(perf_stall_q);
      end
      if (flush_e && (state_q != StInit)) begin
        perf_flush_q <= sat_inc32(perf_flush_q);
      end
      if (state_q == StMemWait) begin
        perf_memwait_q <= sat_inc32(perf_memwait_q);
      end
    end
  end

  assign bus.perf_stall   = perf_stall_q;
  assign bus.perf_flush   = perf_flush_q;
  assign bus.perf_memwait = perf_memwait_q;
`else
  assign bus.perf_stall   = '0;
  assign bus.perf_flush   = '0;
  assign bus.perf_memwait = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (STARTUP_FLUSH=2, MEM_TIMEOUT=8).
// Inputs change just after each falling edge; outputs are checked 1 ns later.
// ctl packs {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

  hazard_ctrl #(
    .REG_ADDR_W    (5),
    .STARTUP_FLUSH (2),
    .MEM_TIMEOUT   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] ctl;
  assign ctl = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                bus.FlushD, bus.FlushE, bus.FlushW};

  localparam logic [6:0] CtlFlushAll = 7'b0000111;
  localparam logic [6:0] CtlIdle     = 7'b0000000;
  localparam logic [6:0] CtlLoadUse  = 7'b1100010;
  localparam logic [6:0] CtlBranch   = 7'b0000110;
  localparam logic [6:0] CtlMemStall = 7'b1111001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0;
    bus.RdE = '0; bus.RdM = '0; bus.RdW = '0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.ResultSrcE = 2'b00;
    bus.PCSrcE = 1'b0; bus.MemReqM = 1'b0; bus.mem_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear();
    rst_n = 1'b0;

    // Reset values
    #1;
    chk("rst_ctl", 32'(ctl), 32'(CtlFlushAll));
    chk("rst_err", 32'(bus.mem_err), 32'd0);
    bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.Rs1E = 5'd5;
    #1;
    chk("rst_fwd", 32'(bus.ForwardAE), 32'd0);
    clear();

    // Startup flush: exactly two cycles after release
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("init_c1", 32'(ctl), 32'(CtlFlushAll));
    @(negedge clk); #1;
    chk("init_c2", 32'(ctl), 32'(CtlFlushAll));
    @(negedge clk); #1;
    chk("run_c0", 32'(ctl), 32'(CtlIdle));

    // Three load-use cycles (Rs2D, Rs1D, Rs2D matches)
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ResultSrcE = 2'b01; bus.RdE = 5'd7;
      bus.Rs2D = (i != 1) ? 5'd7 : 5'd0;
      bus.Rs1D = (i == 1) ? 5'd7 : 5'd0;
      #1;
      chk("lw_stall", 32'(ctl), 32'(CtlLoadUse));
    end
    @(negedge clk); bus.PCSrcE = 1'b1; #1;
    chk("lw_branch", 32'(ctl), 32'(CtlBranch));
    @(negedge clk); bus.PCSrcE = 1'b0; bus.RdE = 5'd0; #1;
    chk("lw_rd0", 32'(ctl), 32'(CtlIdle));
    @(negedge clk); bus.RdE = 5'd7; bus.ResultSrcE = 2'b10; #1;
    chk("no_load", 32'(ctl), 32'(CtlIdle));

    // Memory wait: ready low 3 cycles, high on the 4th
    @(negedge clk); clear(); bus.MemReqM = 1'b1; #1;
    chk("mw_c1", 32'(ctl), 32'(CtlMemStall));
    @(negedge clk);
    bus.PCSrcE = 1'b1; bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.Rs1E = 5'd5;
    #1;
    chk("mw_c2", 32'(ctl), 32'(CtlMemStall));
    chk("mw_c2_fwd", 32'(bus.ForwardAE), 32'd2);
    @(negedge clk); #1;
    chk("mw_c3", 32'(ctl), 32'(CtlMemStall));
    @(negedge clk); bus.mem_ready = 1'b1; #1;
    chk("mw_c4", 32'(ctl), 32'(CtlMemStall));
    @(negedge clk); bus.PCSrcE = 1'b0; #1;
    chk("mw_c5_run", 32'(ctl), 32'(CtlIdle));
    chk("mw_err", 32'(bus.mem_err), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall", bus.perf_stall, 32'd7);
    chk("perf_memwait", bus.perf_memwait, 32'd3);
    chk("perf_flush", bus.perf_flush, 32'd4);
`else
    chk("perf_stall_off", bus.perf_stall, 32'd0);
    chk("perf_memwait_off", bus.perf_memwait, 32'd0);
    chk("perf_flush_off", bus.perf_flush, 32'd0);
`endif

    // Forwarding
    @(negedge clk); clear();
    bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.RegWriteW = 1'b1; bus.RdW = 5'd5;
    bus.Rs1E = 5'd5; bus.Rs2E = 5'd3;
    #1;
    chk("fwd_a_mem", 32'(bus.ForwardAE), 32'd2);
    chk("fwd_b_none", 32'(bus.ForwardBE), 32'd0);
    @(negedge clk); bus.RdM = 5'd0; #1;
    chk("fwd_a_wb", 32'(bus.ForwardAE), 32'd1);
    @(negedge clk); bus.RdW = 5'd0; bus.Rs2E = 5'd0; #1;
    chk("fwd_b_x0", 32'(bus.ForwardBE), 32'd0);
    chk("fwd_a_x0", 32'(bus.ForwardAE), 32'd0);
    @(negedge clk);
    bus.RegWriteM = 1'b0; bus.RdM = 5'd9; bus.RdW = 5'd9; bus.Rs1E = 5'd9; bus.Rs2E = 5'd9;
    #1;
    chk("fwd_b_wb", 32'(bus.ForwardBE), 32'd1);
    chk("fwd_a_wb2", 32'(bus.ForwardAE), 32'd1);
    @(negedge clk); bus.RegWriteW = 1'b0; #1;
    chk("fwd_b_nowe", 32'(bus.ForwardBE), 32'd0);

    // mem_ready arriving on the last allowed wait cycle returns to RUN
    @(negedge clk); clear(); bus.MemReqM = 1'b1; #1;
    chk("tb_c1", 32'(ctl), 32'(CtlMemStall));
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk); #1;
      chk("tb_wait", 32'(ctl), 32'(CtlMemStall));
    end
    @(negedge clk); bus.mem_ready = 1'b1; #1;
    chk("tb_c8", 32'(ctl), 32'(CtlMemStall));
    @(negedge clk); clear(); #1;
    chk("tb_run", 32'(ctl), 32'(CtlIdle));
    chk("tb_err", 32'(bus.mem_err), 32'd0);

    // Timeout: 8 stalled cycles, then ERR
    @(negedge clk); bus.MemReqM = 1'b1; #1;
    chk("to_c1", 32'(ctl), 32'(CtlMemStall));
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk); #1;
      chk("to_wait", 32'(ctl), 32'(CtlMemStall));
      chk("to_wait_err", 32'(bus.mem_err), 32'd0);
    end
    @(negedge clk); #1;
    chk("to_err", 32'(bus.mem_err), 32'd1);
    chk("to_err_ctl", 32'(ctl), 32'(CtlMemStall));
    @(negedge clk); bus.mem_ready = 1'b1; #1;
    chk("err_sticky1", 32'(bus.mem_err), 32'd1);
    @(negedge clk); clear(); #1;
    chk("err_sticky2", 32'(bus.mem_err), 32'd1);
    chk("err_ctl", 32'(ctl), 32'(CtlMemStall));

    // Reset pulse clears the error
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rst2_ctl", 32'(ctl), 32'(CtlFlushAll));
    chk("rst2_err", 32'(bus.mem_err), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("rst2_perf", bus.perf_stall, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1; #1;
    chk("init2_c1", 32'(ctl), 32'(CtlFlushAll));
    @(negedge clk); #1;
    chk("init2_c2", 32'(ctl), 32'(CtlFlushAll));
    @(negedge clk); #1;
    chk("run2", 32'(ctl), 32'(CtlIdle));

    // Reset asserted mid MEM_WAIT
    @(negedge clk); bus.MemReqM = 1'b1; #1;
    chk("mr_c1", 32'(ctl), 32'(CtlMemStall));
    @(negedge clk); bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.Rs1E = 5'd5; #1;
    chk("mr_c2", 32'(ctl), 32'(CtlMemStall));
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mr_rst_ctl", 32'(ctl), 32'(CtlFlushAll));
    chk("mr_rst_fwd", 32'(bus.ForwardAE), 32'd0);
    chk("mr_rst_err", 32'(bus.mem_err), 32'd0);
    @(negedge clk); rst_n = 1'b1; clear(); #1;
    chk("mr_init1", 32'(ctl), 32'(CtlFlushAll));
    @(negedge clk); #1;
    chk("mr_init2", 32'(ctl), 32'(CtlFlushAll));
    @(negedge clk); #1;
    chk("mr_run", 32'(ctl), 32'(CtlIdle));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and pipeline-sequencing controller for the 5-stage RISC-V core.
- Drives operand forwarding select, per-register stall/flush controls for the F/D, D/E, E/M and M/W pipeline registers, and a data-memory wait handshake.
- Holds sequential state for post-reset pipeline flush, data-memory wait tracking with timeout, and a sticky error flag.

Parameters:
- REG_ADDR_W, 5, register-index width
- STARTUP_FLUSH, 2, cycles of forced flush after reset release (1..15)
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before error (2..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Rs1D, Rs2D  in  5  source regs in Decode
- Rs1E, Rs2E  in  5  source regs in Execute
- RdE, RdM, RdW  in  5  dest regs in E/M/W
- RegWriteM, RegWriteW  in  1  dest write enables in M/W
- ResultSrcE  in  2  result source in E; 2'b01 = load
- PCSrcE  in  1  taken branch/jump resolved in E
- MemReqM  in  1  load/store active in Memory stage
- mem_ready  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 regfile, 01 W result, 10 M ALU result
- StallF, StallD, StallE, StallM  out  1  hold PC / D / E / M registers
- FlushD, FlushE, FlushW  out  1  bubble D / E / W registers
- mem_err  out  1  sticky memory-timeout error
- perf_stall, perf_flush, perf_memwait  out  32 each  performance counters (see Optional Feature)

Behaviour:
- FSM states INIT, RUN, MEM_WAIT, ERR.
- Reset (rst_n low, async):
  - state = INIT, startup counter = STARTUP_FLUSH, timeout counter = 0, mem_err = 0.
  - Outputs: Forward* = 00, Stall* = 0, FlushD/FlushE/FlushW = 1.
- INIT:
  - FlushD/E/W = 1, all stalls 0.
  - Counter decrements each cycle; at 1 -> RUN next cycle.
  - Exactly STARTUP_FLUSH flush cycles after rst_n rises.
- RUN:
  - Forwarding, combinational:
    - ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E;
    - else 01 if RegWriteW && RdW != 0 && RdW == Rs1E;
    - else 00. ForwardBE is identical with Rs2E.
    - M has priority over W.
  - lwStall = (ResultSrcE == 01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
  - StallF = StallD = lwStall; FlushE = lwStall | PCSrcE; FlushD = PCSrcE.
  - If PCSrcE && lwStall: branch wins. StallF = StallD = 0, FlushD = FlushE = 1.
  - MemReqM && !mem_ready: same cycle, assert StallF/D/E/M = 1 and FlushW = 1; all other flushes 0. Next state MEM_WAIT.
  - MemReqM && mem_ready: no stall.
- MEM_WAIT:
  - StallF/D/E/M = 1, FlushW = 1, FlushD/FlushE = 0. Forward* computed as in RUN.
  - Timeout counter increments each cycle.
  - mem_ready = 1: outputs still stalled this cycle, counter cleared, -> RUN.
  - Counter reaches MEM_TIMEOUT-1 without mem_ready: -> ERR.
  - mem_ready on the timeout cycle takes priority (-> RUN).
- ERR:
  - mem_err = 1, all stalls 1, FlushW = 1.
  - Left only by reset.
- Reset mid-MEM_WAIT or mid-INIT: immediate return to reset values; no carry-over.
- Counter widths: ceil(log2(MEM_TIMEOUT+1)), ceil(log2(STARTUP_FLUSH+1)). No wrap.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - perf_stall counts cycles with StallF = 1.
  - perf_flush counts cycles with FlushE = 1 outside INIT.
  - perf_memwait counts cycles in MEM_WAIT.
  - All 32-bit, saturating at 32'hFFFF_FFFF, cleared by reset.
- Undefined: counters not instantiated; ports driven to 0.

Decomposition:
- hazard_pkg holds:
  - state enum (INIT, RUN, MEM_WAIT, ERR);
  - forward codes FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - RESULT_SRC_LOAD = 2'b01.
- One sub-module, hazard_fwd_unit: purely combinational forwarding for one operand, instantiated twice.

Test Plan:
- Reset release, STARTUP_FLUSH = 2 -> FlushD/E/W = 1 for exactly 2 cycles, then 0; state RUN.
- RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10; with RdM = 0 -> ForwardAE = 01; Rs2E = 0 with RdW = 0 -> ForwardBE = 00.
- ResultSrcE = 01, RdE = 7, Rs2D = 7, PCSrcE = 0 -> StallF = StallD = FlushE = 1 for one cycle; add PCSrcE = 1 -> StallF = 0, FlushD = FlushE = 1.
- MemReqM = 1, mem_ready low 3 cycles then high -> Stall* = 1 and FlushW = 1 for 4 cycles, RUN on cycle 5, mem_err = 0.
- MEM_TIMEOUT = 8, mem_ready held 0 -> ERR after 8 stalled cycles, mem_err = 1 sticky until rst_n pulse; rst_n asserted during MEM_WAIT -> immediate reset outputs.
- HAZARD_PERF_EN: 3-cycle load-use + 4-cycle memory wait -> perf_stall = 7, perf_memwait = 3 (MEM_WAIT cycles only); without macro all perf ports = 0.
